// File: rtl/vic_pkg.sv
// vic_pkg: shared types and helpers for the vectored interrupt controller.
//   vic_state_e : request FSM states (IDLE, REQ, BLANK)
//   vic_ffs     : index of lowest set bit of a 16-bit vector (0 when empty)
package vic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BLANK = 2'd2
  } vic_state_e;

  localparam int VIC_MAX_CH = 16;

  function automatic logic [3:0] vic_ffs(input logic [VIC_MAX_CH-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = VIC_MAX_CH - 1; i >= 0; i--)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: lowest-index-first priority encoder.
//   req [N-1:0]  : request bits, bit 0 highest priority
//   idx [IW-1:0] : index of lowest set request bit (0 when none)
//   vld          : at least one request bit set
module vic_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Scan from the top so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_int_ctrl.sv
// vec_int_ctrl: N-channel vectored fixed-priority interrupt controller.
//   g_clk, g_clr    : clock (rising edge), async active-low reset
//   int_req         : raw asynchronous requests, one per channel
//   ien             : global interrupt enable
//   mask_wr/mask_in : load channel mask (1 = masked)
//   int_ack         : controller takes the presented vector
//   int_done        : return-from-interrupt, retires lowest-index in-service bit
//   i_pending       : registered request to the controller
//   vec_out         : registered vector, VEC_BASE + idx*VEC_STRIDE
//   in_service      : channels currently being serviced
//   mask_out        : current mask
// Build option VIC_NESTING_EN: when defined, a channel of strictly higher
// priority than every in-service channel may preempt; otherwise nothing is
// presented while any channel is in service.
module vec_int_ctrl
  import vic_pkg::*;
#(
  parameter int               N_CH       = 4,
  parameter int               VEC_W      = 8,
  parameter logic [VEC_W-1:0] VEC_BASE   = 8'h40,
  parameter int               VEC_STRIDE = 4,
  parameter logic [N_CH-1:0]  EDGE_MASK  = '1
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [N_CH-1:0]  int_req,
  input  logic             ien,
  input  logic             mask_wr,
  input  logic [N_CH-1:0]  mask_in,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             i_pending,
  output logic [VEC_W-1:0] vec_out,
  output logic [N_CH-1:0]  in_service,
  output logic [N_CH-1:0]  mask_out
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] sync1, sync2, dly, pend, pend_nxt, mask;
  logic [N_CH-1:0] rise, allow, elig, is_nxt, done_clr;
  logic [IW-1:0]   cur_idx, cand_idx;
  logic            cand_vld, ack_take;
  logic [3:0]      done_idx;
  vic_state_e      state;

  function automatic logic [VEC_W-1:0] vec_of(input logic [IW-1:0] idx);
    return VEC_BASE + VEC_W'(32'(idx) * VEC_STRIDE);
  endfunction

  // Two-flop synchroniser plus delay flop for edge detection.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      sync1 <= '0;
      sync2 <= '0;
      dly   <= '0;
    end else begin
      sync1 <= int_req;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise     = sync2 & ~dly;
  assign ack_take = (state == ST_REQ) && int_ack;

  // A rise coinciding with the ack of the same channel keeps it pending.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < N_CH; i++) begin
      if (EDGE_MASK[i])
        pend_nxt[i] = rise[i] | (pend[i] & ~(ack_take && (cur_idx == IW'(i))));
      else
        pend_nxt[i] = sync2[i];
    end
  end

  // Done retires against the old in-service value, then the ack bit lands.
  assign done_idx = vic_ffs(16'(in_service));
  assign done_clr = (int_done && (in_service != '0)) ? (N_CH'(1) << done_idx) : '0;

  always_comb begin
    is_nxt = in_service & ~done_clr;
    if (ack_take) is_nxt = is_nxt | (N_CH'(1) << cur_idx);
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      pend       <= '0;
      in_service <= '0;
      mask       <= '1;
    end else begin
      pend       <= pend_nxt;
      in_service <= is_nxt;
      if (mask_wr) mask <= mask_in;
    end
  end

  assign mask_out = mask;

`ifdef VIC_NESTING_EN
  logic [IW-1:0] is_idx;
  logic          is_vld;

  vic_prio_enc #(.N(N_CH), .IW(IW)) u_is_enc (
    .req (in_service),
    .idx (is_idx),
    .vld (is_vld)
  );

  // Only channels strictly above the highest-priority in-service one.
  assign allow = is_vld ? ((N_CH'(1) << is_idx) - N_CH'(1)) : '1;
`else
  assign allow = (in_service == '0) ? '1 : '0;
`endif

  assign elig = pend & ~mask & allow;

  vic_prio_enc #(.N(N_CH), .IW(IW)) u_cand_enc (
    .req (elig),
    .idx (cand_idx),
    .vld (cand_vld)
  );

  // REQ re-arbitrates every cycle except the ack cycle, so vec_out is
  // stable whenever the controller samples int_ack.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state     <= ST_IDLE;
      i_pending <= 1'b0;
      vec_out   <= '0;
      cur_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ien && cand_vld) begin
            state     <= ST_REQ;
            i_pending <= 1'b1;
            vec_out   <= vec_of(cand_idx);
            cur_idx   <= cand_idx;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state     <= ST_BLANK;
            i_pending <= 1'b0;
          end else if (!(ien && cand_vld)) begin
            state     <= ST_IDLE;
            i_pending <= 1'b0;
          end else begin
            vec_out <= vec_of(cand_idx);
            cur_idx <= cand_idx;
          end
        end
        ST_BLANK: state <= ST_IDLE;
        default: begin
          state     <= ST_IDLE;
          i_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
